// File: rtl/alu_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_mult_seq                                               |
// | Purpose : Iterative 32x32->64 MULT/MULTU sequencer. Borrows the      |
// |           shared ALU through req/gnt for a shift-add loop and        |
// |           delivers HI/LO with busy/done for hazard stalling.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module alu_mult_seq #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32   // one iteration per multiplier bit; keep equal to WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             alu_gnt,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam int         c_CNT_W   = $clog2(ITERS) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_sign;
  logic                 r_signed_op;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_carry;
  logic [WIDTH:0]       w_sum;
  logic                 w_last;
  logic                 w_abort;
  logic [2*WIDTH-1:0]   w_prod_neg;

  // The ALU add wrapped iff its result is smaller than the hi operand.
  assign w_carry    = (alu_result < r_hi);
  // 33-bit partial sum; shifting it right by one gives the new hi and the bit fed into lo.
  assign w_sum      = r_lo[0] ? {w_carry, alu_result} : {1'b0, r_hi};
  assign w_last     = (r_cnt == c_CNT_W'(ITERS - 1));
  assign w_abort    = flush && (r_state != S_IDLE);
  // Final sign correction is done locally so FIX never waits on the ALU.
  assign w_prod_neg = (~{r_hi, r_lo}) + (2*WIDTH)'(1);

  assign hi = r_hi;
  assign lo = r_lo;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and ALU/status outputs.
  always_comb begin
    w_state_nxt = r_state;
    alu_req     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctl     = 3'b000;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !flush) w_state_nxt = is_signed ? S_NEG_A : S_ITER;
      end
      S_NEG_A: begin
        alu_req = 1'b1;
        alu_b   = r_mcand;
        alu_ctl = c_ALU_SUB;
        if (alu_gnt) w_state_nxt = S_NEG_B;
      end
      S_NEG_B: begin
        alu_req = 1'b1;
        alu_b   = r_lo;
        alu_ctl = c_ALU_SUB;
        if (alu_gnt) w_state_nxt = S_ITER;
      end
      S_ITER: begin
        alu_req = 1'b1;
        alu_a   = r_hi;
        alu_b   = r_mcand;
        alu_ctl = c_ALU_ADD;
        if (alu_gnt && w_last) w_state_nxt = r_signed_op ? S_FIX : S_DONE;
      end
      S_FIX: w_state_nxt = S_DONE;
      S_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A pipeline flush abandons any operation in flight.
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Operand capture, sign-magnitude conversion, shift-add loop and final negate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_sign      <= 1'b0;
      r_signed_op <= 1'b0;
      r_cnt       <= '0;
    end else if (!w_abort) begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_sign      <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_signed_op <= is_signed;
            r_mcand     <= op_a;
            r_hi        <= '0;
            r_lo        <= op_b;
            r_cnt       <= '0;
          end
        end
        S_NEG_A: if (alu_gnt && r_mcand[WIDTH-1]) r_mcand <= alu_result;
        S_NEG_B: if (alu_gnt && r_lo[WIDTH-1])    r_lo    <= alu_result;
        S_ITER: begin
          if (alu_gnt) begin
            r_hi  <= w_sum[WIDTH:1];
            r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_FIX: if (r_sign) {r_hi, r_lo} <= w_prod_neg;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_mult_seq                                            |
// | Purpose : Self-checking bench for alu_mult_seq with a behavioural    |
// |           ALU and a scoreboard of expected products and latencies.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_mult_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, flush, alu_gnt;
  logic [31:0] op_a, op_b, alu_result;
  logic        alu_req, busy, done;
  logic [31:0] alu_a, alu_b, hi, lo;
  logic [2:0]  alu_ctl;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_mult_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .alu_gnt(alu_gnt),
    .alu_result(alu_result), .alu_req(alu_req), .alu_a(alu_a),
    .alu_b(alu_b), .alu_ctl(alu_ctl), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared ALU.
  always_comb begin
    alu_result = 32'h0;
    if (alu_ctl == 3'b010)      alu_result = alu_a + alu_b;
    else if (alu_ctl == 3'b110) alu_result = alu_a - alu_b;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    if (sgn) begin
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      return sa * sbv;
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hilo"}, {hi, lo}, 64'h0);
    check({tag, "_ctl"}, {busy, done, alu_req, alu_ctl}, 6'h0);
    check({tag, "_ab"}, {alu_a, alu_b}, 64'h0);
  endtask

  // Launch one op, push its expectation, run to done, pop and compare.
  // stall: deny grant in cycle 1 and cycles 10-14. poke: pulse start mid-op.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input bit stall, input bit poke);
    exp_t e;
    int   cyc;
    bit   seen, busy_ok, req_ok;
    e.prod = model(sgn, a, b);
    e.lat  = lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; is_signed = ~sgn; op_a = $urandom; op_b = $urandom;
    cyc = 1; seen = 0; busy_ok = 1; req_ok = 1;
    while (!seen && cyc < 120) begin
      alu_gnt = !(stall && (cyc == 1 || (cyc >= 10 && cyc < 15)));
      start   = poke && (cyc == 5);
      if (done) seen = 1;
      else begin
        if (!busy) busy_ok = 0;
        if (!sgn && !alu_req) req_ok = 0;
        @(negedge clk);
        cyc++;
      end
    end
    start   = 1'b0;
    alu_gnt = 1'b1;
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_busy_held"}, busy_ok, 1'b1);
    if (!sgn) check({tag, "_req_held"}, req_ok, 1'b1);
    e = sb.pop_front();
    check({tag, "_latency"}, cyc, e.lat);
    check({tag, "_product"}, {hi, lo}, e.prod);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, {hi, lo}, e.prod);
  endtask

  initial begin
    int  cnt;
    bit  quiet;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0; alu_gnt = 1'b1;
    op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_op("multu_7x6",   1'b0, 32'd7,        32'd6,        33, 1'b0, 1'b0);
    run_op("multu_ffff",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0, 1'b0);
    run_op("mult_m3x5",   1'b1, 32'hFFFFFFFD, 32'd5,        36, 1'b0, 1'b0);
    run_op("mult_min",    1'b1, 32'h80000000, 32'h80000000, 36, 1'b0, 1'b0);
    run_op("multu_stall", 1'b0, 32'd7,        32'd6,        39, 1'b1, 1'b0);
    run_op("multu_zero",  1'b0, 32'h12345678, 32'h0,        33, 1'b0, 1'b0);
    run_op("mult_negneg", 1'b1, 32'hFFFF0001, 32'h80000001, 36, 1'b0, 1'b0);
    run_op("multu_poke",  1'b0, 32'hDEADBEEF, 32'h00C0FFEE, 33, 1'b0, 1'b1);
    run_op("mult_rand",   1'b1, $urandom,     $urandom,     36, 1'b0, 1'b0);

    // flush during ITER: idle next cycle, no done ever.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {busy, done}, 2'b00);
    quiet = 1;
    for (cnt = 0; cnt < 40; cnt++) begin
      if (done || busy) quiet = 0;
      @(negedge clk);
    end
    check("flush_no_done", quiet, 1'b1);

    // flush together with start in IDLE: start ignored.
    start = 1'b1; flush = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {busy, alu_req}, 2'b00);

    // rst mid-ITER overrides flush and start.
    start = 1'b1; is_signed = 1'b0; op_a = 32'hA5A5A5A5; op_b = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1; flush = 1'b1; start = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("after_rst_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Iterative 32x32 -> 64-bit multiply sequencer for the MULT/MULTU path of the pipeline CPU.
- Owns no adder of its own. It borrows the shared 32-bit ALU through a request/grant handshake and drives the ALU's a, b and ctl inputs.
- Runs a shift-add loop, one ALU add per multiplier bit.
- Delivers HI/LO to the register file / HI-LO registers, with busy/done for hazard stalling.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each.
- ITERS, 32, loop count; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  launch request; sampled in IDLE only.
- is_signed  in  1  1=MULT (two's complement), 0=MULTU; sampled with start.
- op_a  in  32  multiplicand; sampled with start.
- op_b  in  32  multiplier; sampled with start.
- flush  in  1  abort current operation (pipeline flush).
- alu_gnt  in  1  ALU granted to this block this cycle.
- alu_result  in  32  ALU result for the a/b/ctl driven this cycle.
- alu_req  out  1  requests the ALU.
- alu_a  out  32  ALU input a.
- alu_b  out  32  ALU input b.
- alu_ctl  out  3  ALU op: ADD=3'b010, SUB=3'b110.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  32  product bits 63:32.
- lo  out  32  product bits 31:0.

Behaviour:
- Interface basics: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; hi=0, lo=0, busy=0, done=0, alu_req=0, alu_a=0, alu_b=0, alu_ctl=3'b000.
- States: IDLE, NEG_A, NEG_B, ITER, FIX, DONE.
- IDLE:
  - On start=1, latch sign=op_a[31]^op_b[31] (forced 0 if is_signed=0), mcand=op_a, hi=0, lo=op_b, cnt=0.
  - Next state is NEG_A if is_signed, else ITER.
- ALU-using states (NEG_A, NEG_B, ITER):
  - alu_req=1 and outputs are driven.
  - State and registers advance only in cycles with alu_gnt=1; with alu_gnt=0 everything holds.
  - In all other states, alu_req=0 and alu_a/alu_b/alu_ctl=0.
- NEG_A:
  - alu_a=0, alu_b=mcand, ctl=SUB.
  - On grant: if mcand[31], mcand<=alu_result; else unchanged. Next state NEG_B.
  - Signed ops always spend this cycle, even for positive operands.
- NEG_B:
  - Same as NEG_A, applied to lo (the multiplier). Next state ITER.
- ITER:
  - alu_a=hi, alu_b=mcand, ctl=ADD.
  - carry = (alu_result < hi), unsigned compare.
  - sum33 = lo[0] ? {carry, alu_result} : {1'b0, hi}.
  - On grant: hi<=sum33[32:1]; lo<={sum33[0], lo[31:1]}; cnt<=cnt+1.
  - After the ITERS-th granted iteration: next state FIX if signed op, else DONE.
- FIX:
  - If sign=1, {hi,lo} <= ~{hi,lo} + 1, as an internal 64-bit negate (not via the ALU).
  - Next state DONE. Takes one cycle; no grant needed.
- DONE:
  - done=1 for exactly this cycle, busy=0. Next state IDLE.
- hi/lo outputs:
  - Hold their final value from DONE until the next accepted start.
  - During an operation they show intermediate state; consumers use done only.
- Latency with continuous grant (start sampled at cycle 0):
  - Unsigned: done at cycle 33.
  - Signed: done at cycle 36.
  - Each non-granted cycle adds 1.
- start handling:
  - start outside IDLE is ignored (no queueing).
  - The earliest next launch is the cycle after DONE.
- flush:
  - In any non-IDLE state, next state is IDLE and no done is produced; hi/lo are left as-is.
  - Flush takes priority over grant and over FIX/DONE transitions. If flush=1 in DONE, the done pulse still asserts that cycle.
  - flush and start together in IDLE: start is ignored.
- rst mid-operation: returns to the reset values on the next edge, overriding flush and start.
- Corner cases:
  - op = 0x80000000 signed: negation yields 0x80000000, treated as unsigned 2^31; the result is correct.
  - Multiplier = 0: all iterations take the lo[0]=0 path, but the loop still runs the full ITERS iterations (fixed latency).

Test Plan:
- MULTU 7 x 6, grant tied 1 -> done pulse at cycle 33, hi=0x00000000, lo=0x0000002A; busy high cycles 1-32.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises carry path every iteration).
- MULT -3 x 5 -> done at cycle 36, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- MULTU 7 x 6 with alu_gnt low for 5 cycles in ITER and 1 cycle in the first ITER cycle -> done at cycle 39; same result; alu_req stays high throughout.
- Unsigned op with flush at cycle 10 -> IDLE at cycle 11, no done. Then start ignored while busy; rst asserted mid-ITER -> all outputs equal reset values next cycle.
